muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the execute stage and runs a 32-iteration shift-add or restoring-divide loop. It serves MFHI/MFLO reads to the ALU/mult result path and raises a stall to the hazard logic whenever an execute-stage HI/LO consumer would collide with an operation in flight.

## Interface

Parameters: none (datapath fixed at 32 bits).

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- startE  in  1  execute stage holds a mult/div instruction
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srcAE  in  32  operand A, dividend, or MTHI/MTLO data
- srcBE  in  32  operand B or divisor
- mthiE  in  1  execute stage holds MTHI
- mtloE  in  1  execute stage holds MTLO
- mfE  in  1  execute stage holds MFHI/MFLO
- hiSelE  in  1  1 selects HI, 0 selects LO for HiLoOutE
- busy  out  1  registered; operation in flight
- stallMD  out  1  combinational: busy & (startE | mthiE | mtloE | mfE)
- HiLoOutE  out  32  combinational: hiSelE ? HI : LO
- HI  out  32  registered HI
- LO  out  32  registered LO

## Operation

- States: IDLE, MUL, DIV, FIX. Reset: state IDLE, busy 0, HI 0, LO 0, counter 0.
- IDLE, startE=1: latch operand magnitudes (signed ops take two's-complement absolute value; unsigned ops pass through), latch result signs, load counter 31, go to MUL (op 0x) or DIV (op 1x); busy <= 1.
- Signed result signs: product and quotient negative iff operand signs differ; remainder takes the dividend sign.
- MUL: one shift-add step per cycle on a 64-bit accumulator; decrement counter; at counter 0 go to FIX.
- DIV: one restoring step per cycle (shift remainder left, trial-subtract divisor, set quotient bit if non-negative); at counter 0 go to FIX.
- Divide by zero: detected in IDLE at start; skip DIV and go directly to FIX with LO = 0xFFFFFFFF, HI = srcAE (raw, no sign fix).
- FIX: apply sign correction (64-bit negate for product; separate 32-bit negates for quotient and remainder); write HI = product[63:32] or remainder, LO = product[31:0] or quotient; busy <= 0; go to IDLE.
- DIV 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0; no trap.
- IDLE, mthiE: HI <= srcAE. IDLE, mtloE: LO <= srcAE. Both asserted writes both.
- Priority in IDLE: startE over mthiE/mtloE; the decoder never asserts both, and startE wins if it does.
- While busy: startE, mthiE, and mtloE are ignored and stallMD holds the instruction in execute until it is reissued in IDLE. HI/LO are not modified until FIX.
- An asynchronous rst in any state aborts the operation and returns to reset values immediately.

## Timing

- Start edge = E0 (IDLE samples startE). MUL/DIV iterations occupy edges E1..E32; FIX writes HI/LO at E33.
- busy is high for exactly 33 cycles (after E0 through E33); it is high for 1 cycle on divide by zero, with the write at E1.
- stallMD rises the cycle after E0 if an HI/LO consumer is in execute. It falls in the cycle following E33, when new HI/LO is already visible on HiLoOutE.
- MTHI/MTLO in IDLE take effect at the next edge; an MFHI/MFLO in the following cycle reads the new value.
- The counter is 5 bits and never wraps: it is loaded to 31 and exits at 0.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy 33 cycles, then HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT -3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB at E33.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 0x64 / 0 -> busy exactly 1 cycle, LO = 0xFFFFFFFF, HI = 0x00000064.
- MFLO (mfE=1, hiSelE=0) held from E1 during MULT 5 × 6 -> stallMD = 1 for 33 cycles, then 0 with HiLoOutE = 30. An MTHI 0x1234 during busy is ignored; reissued in IDLE, HI = 0x1234.
- rst pulse at E10 of a DIV -> busy, HI, LO go to 0 without a clock edge. A fresh MULTU 2 × 3 then yields LO = 6.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_if.sv
// rtl/muldiv_hilo_ctrl_if.sv - execute-stage mult/div and HI/LO access bundle
interface muldiv_hilo_ctrl_if;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        mthiE;
  logic        mtloE;
  logic        mfE;
  logic        hiSelE;
  logic        busy;
  logic        stallMD;
  logic [31:0] HiLoOutE;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output startE, opE, srcAE, srcBE, mthiE, mtloE, mfE, hiSelE,
    input  busy, stallMD, HiLoOutE, HI, LO
  );

  modport slave (
    input  startE, opE, srcAE, srcBE, mthiE, mtloE, mfE, hiSelE,
    output busy, stallMD, HiLoOutE, HI, LO
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - iterative mult/div sequencer owning the HI/LO pair
module muldiv_hilo_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  muldiv_hilo_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // acc holds {upper, lower} of the product, or {remainder, quotient/dividend}
  logic [63:0] acc_q, acc_d;
  logic [31:0] opa_q, opa_d;
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;

  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        div_zero;
  logic [32:0] sum33;
  logic [63:0] mul_next;
  logic [32:0] shifted, diff;
  logic        q_bit;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~bus.opE[0];
  assign a_neg     = signed_op & bus.srcAE[31];
  assign b_neg     = signed_op & bus.srcBE[31];
  assign mag_a     = a_neg ? (~bus.srcAE + 32'd1) : bus.srcAE;
  assign mag_b     = b_neg ? (~bus.srcBE + 32'd1) : bus.srcBE;
  assign div_zero  = bus.opE[1] & (bus.srcBE == 32'd0);

  // Shift-add: add multiplicand to the upper half when the low bit is set, then shift right
  assign sum33    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
  assign mul_next = {sum33, acc_q[31:1]};

  // Restoring step: remainder stays below the divisor, so 33 bits cover the trial
  assign shifted  = {acc_q[63:32], acc_q[31]};
  assign diff     = shifted - {1'b0, opa_q};
  assign q_bit    = ~diff[32];
  assign div_next = {(q_bit ? diff[31:0] : shifted[31:0]), acc_q[30:0], q_bit};

  assign prod    = neg_p_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix = neg_p_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_q    <= 64'd0;
      opa_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.startE) begin
          if (div_zero)          state_d = S_FIX;
          else if (bus.opE[1])   state_d = S_DIV;
          else                   state_d = S_MUL;
        end
      end
      S_MUL:   if (cnt_q == 5'd0) state_d = S_FIX;
      S_DIV:   if (cnt_q == 5'd0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    busy_d   = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.startE) begin
          cnt_d    = 5'd31;
          is_div_d = bus.opE[1];
          neg_p_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          if (div_zero) begin
            // Raw dividend into HI, all-ones into LO, bypassing sign correction
            acc_d   = {bus.srcAE, 32'hFFFF_FFFF};
            neg_p_d = 1'b0;
            neg_r_d = 1'b0;
          end else if (bus.opE[1]) begin
            acc_d = {32'd0, mag_a};
            opa_d = mag_b;
          end else begin
            acc_d = {32'd0, mag_b};
            opa_d = mag_a;
          end
        end else begin
          if (bus.mthiE) hi_d = bus.srcAE;
          if (bus.mtloE) lo_d = bus.srcAE;
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      S_DIV: begin
        acc_d = div_next;
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      S_FIX: begin
        cnt_d = 5'd0;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.stallMD  = busy_q & (bus.startE | bus.mthiE | bus.mtloE | bus.mfE);
  assign bus.HiLoOutE = bus.hiSelE ? hi_q : lo_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - self-checking bench for muldiv_hilo_ctrl
module tb_muldiv_hilo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  muldiv_hilo_ctrl_if bus();

  muldiv_hilo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; pu = p; hi = pu[63:32]; lo = pu[31:0]; end
      2'b01: begin pu = 64'(a) * 64'(b); hi = pu[63:32]; lo = pu[31:0]; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.startE = 1'b1; bus.opE = op; bus.srcAE = a; bus.srcBE = b;
    @(negedge clk);
    bus.startE = 1'b0; bus.srcAE = $urandom; bus.srcBE = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    logic [31:0] ehi, elo;
    start_op(op, a, b);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, 32'(cycles), (op[1] && b == 0) ? 32'd1 : 32'd33);
    model(op, a, b, ehi, elo);
    chk({tag, ".HI"}, bus.HI, ehi);
    chk({tag, ".LO"}, bus.LO, elo);
    bus.hiSelE = 1'b1; #1;
    chk({tag, ".out_hi"}, bus.HiLoOutE, ehi);
    bus.hiSelE = 1'b0; #1;
    chk({tag, ".out_lo"}, bus.HiLoOutE, elo);
  endtask

  initial begin
    int cycles;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    bus.startE = 0; bus.opE = 0; bus.srcAE = 0; bus.srcBE = 0;
    bus.mthiE = 0; bus.mtloE = 0; bus.mfE = 0; bus.hiSelE = 0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.HI", bus.HI, 32'd0);
    chk("reset.LO", bus.LO, 32'd0);
    chk("reset.stall", 32'(bus.stallMD), 32'd0);
    rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max.hi_const", bus.HI, 32'hFFFF_FFFE);
    chk("multu_max.lo_const", bus.LO, 32'h0000_0001);
    run_op("mult_neg", 2'b00, -32'sd3, 32'd7);
    chk("mult_neg.lo_const", bus.LO, 32'hFFFF_FFEB);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2);
    chk("div_neg.lo_const", bus.LO, 32'hFFFF_FFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7);
    chk("divu.lo_const", bus.LO, 32'd14);
    run_op("divu_zero", 2'b11, 32'h64, 32'd0);
    run_op("div_zero", 2'b10, 32'h8000_0005, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf.lo_const", bus.LO, 32'h8000_0000);
    chk("div_ovf.hi_const", bus.HI, 32'd0);

    // MFLO held through a MULT, plus an MTHI that must be ignored until IDLE
    start_op(2'b00, 32'd5, 32'd6);
    bus.mfE = 1'b1; bus.hiSelE = 1'b0; bus.mthiE = 1'b1; bus.srcAE = 32'h1234;
    cycles = 0;
    while (bus.stallMD && cycles < 100) begin
      cycles++;
      @(negedge clk);
      if (cycles < 33) begin
        total++;
        assert (bus.HI === 32'h0) else begin
          bad++;
          $error("FAIL stall.hi_held observed=%h expected=%h", bus.HI, 32'h0);
        end
      end
    end
    chk("stall.cycles", 32'(cycles), 32'd33);
    chk("stall.mflo", bus.HiLoOutE, 32'd30);
    chk("stall.hi_after_fix", bus.HI, 32'd0);
    @(negedge clk);
    bus.mthiE = 1'b0; bus.mfE = 1'b0;
    chk("mthi_reissue", bus.HI, 32'h1234);

    bus.mtloE = 1'b1; bus.srcAE = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.mtloE = 1'b0; bus.mfE = 1'b1; bus.hiSelE = 1'b0; #1;
    chk("mtlo_then_mflo", bus.HiLoOutE, 32'hA5A5_0F0F);
    chk("idle_no_stall", 32'(bus.stallMD), 32'd0);
    bus.mfE = 1'b0;

    // Asynchronous reset in the middle of a divide
    start_op(2'b10, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.HI", bus.HI, 32'd0);
    chk("rst.LO", bus.LO, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.stays_idle", 32'(bus.busy), 32'd0);
    run_op("post_rst_multu", 2'b01, 32'd2, 32'd3);
    chk("post_rst_multu.lo_const", bus.LO, 32'd6);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 6 == 1) rb = 32'd0;
      if (i % 6 == 3) rb = 32'($urandom_range(1, 20));
      if (i % 6 == 4) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
